// File: rtl/player_bullet_pool_pkg.sv
// Shared screen geometry, {x,y} position packing and fire FSM encoding for the player bullet pool.
package player_bullet_pool_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int X_W      = 10;
  localparam int Y_W      = 9;
  localparam int POS_W    = X_W + Y_W;

  typedef logic [POS_W-1:0] pos_t;

  typedef enum logic [1:0] {
    READY    = 2'd0,
    ARMED    = 2'd1,
    COOLDOWN = 2'd2
  } fire_state_t;

  function automatic pos_t pack_pos(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return {x, y};
  endfunction

  function automatic logic [X_W-1:0] pos_x(input pos_t p);
    return p[POS_W-1:Y_W];
  endfunction

  function automatic logic [Y_W-1:0] pos_y(input pos_t p);
    return p[Y_W-1:0];
  endfunction

endpackage

// File: rtl/player_bullet_pool_lowest_free_slot.sv
// Combinational priority encoder: index of the lowest slot whose live bit is clear, plus a found flag.
// Zero latency; no flow control.
module player_bullet_pool_lowest_free_slot #(
  parameter int N     = 15,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     busy,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan from the top so the lowest free index is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/player_bullet_pool.sv
// Player bullet slots: fire FSM with cooldown, per-frame upward motion, off-screen and hit frees.
// All outputs registered; spawn/move visible 1 cycle after the frame tick, hit clears 1 cycle later.
module player_bullet_pool
  import player_bullet_pool_pkg::*;
#(
  parameter int MAX_PLAYER_BULLET = 15,
  parameter int BULLET_SPEED      = 4,
  parameter int FIRE_COOLDOWN     = 8,
  parameter int SPAWN_X_OFFSET    = 16,
  parameter int SPAWN_Y           = 440
) (
  input  logic                               i_Clk,
  input  logic                               i_Rst_n,
  input  logic                               i_FrameTick,
  input  logic                               i_Fire,
  input  logic                               i_PlayerState,
  input  logic [X_W-1:0]                     i_PlayerPosition,
  input  logic [MAX_PLAYER_BULLET-1:0]       i_HitMask,
  output logic [MAX_PLAYER_BULLET-1:0]       o_PlayerBulletState,
  output logic [POS_W*MAX_PLAYER_BULLET-1:0] o_PlayerBulletPosition,
  output logic                               o_FireAccept
);

  localparam int N     = MAX_PLAYER_BULLET;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CD_W  = (FIRE_COOLDOWN > 0) ? $clog2(FIRE_COOLDOWN + 1) : 1;

  localparam logic [Y_W-1:0]  SPEED_Y = Y_W'(BULLET_SPEED);
  localparam logic [Y_W-1:0]  START_Y = Y_W'(SPAWN_Y);
  localparam logic [X_W:0]    X_OFF   = (X_W + 1)'(SPAWN_X_OFFSET);
  localparam logic [X_W:0]    X_MAX   = (X_W + 1)'(SCREEN_W - 1);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(FIRE_COOLDOWN);

  fire_state_t     fsm;
  logic            pending;
  logic [CD_W-1:0] cooldown;
  logic            fire_accept;

  logic [N-1:0]     live;
  logic [IDX_W-1:0] free_idx;
  logic             free_found;
  logic             spawn;
  logic [N-1:0]     spawn_hot;
  logic [X_W:0]     x_sum;
  logic [X_W-1:0]   spawn_x;
  pos_t             spawn_pos;

  // Free-slot search sees the live bits before this cycle's hit clear.
  player_bullet_pool_lowest_free_slot #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_free (
    .busy  (live),
    .idx   (free_idx),
    .found (free_found)
  );

  assign spawn     = i_PlayerState && (fsm == ARMED) && pending && i_FrameTick && free_found;
  assign spawn_hot = spawn ? (N'(1) << free_idx) : '0;
  assign x_sum     = {1'b0, i_PlayerPosition} + X_OFF;
  assign spawn_x   = (x_sum > X_MAX) ? X_MAX[X_W-1:0] : x_sum[X_W-1:0];
  assign spawn_pos = pack_pos(spawn_x, START_Y);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      fsm         <= READY;
      pending     <= 1'b0;
      cooldown    <= '0;
      fire_accept <= 1'b0;
    end else begin
      fire_accept <= spawn;
      if (!i_PlayerState) begin
        fsm      <= READY;
        pending  <= 1'b0;
        cooldown <= '0;
      end else begin
        case (fsm)
          READY: begin
            if (i_Fire) begin
              pending <= 1'b1;
              fsm     <= ARMED;
            end
          end
          ARMED: begin
            if (i_FrameTick) begin
              pending <= 1'b0;
              if (free_found) begin
                cooldown <= CD_LOAD;
                fsm      <= COOLDOWN;
              end else begin
                fsm <= READY;
              end
            end
          end
          COOLDOWN: begin
            // Fire requests here are dropped, not queued.
            if (cooldown == '0) begin
              fsm <= READY;
            end else if (i_FrameTick) begin
              cooldown <= cooldown - 1'b1;
              if (cooldown == CD_W'(1)) fsm <= READY;
            end
          end
          default: begin
            fsm      <= READY;
            pending  <= 1'b0;
            cooldown <= '0;
          end
        endcase
      end
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_slot
    logic slot_live;
    pos_t slot_pos;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
        slot_live <= 1'b0;
        slot_pos  <= '0;
      end else if (slot_live && i_HitMask[k]) begin
        slot_live <= 1'b0;
      end else if (spawn_hot[k]) begin
        slot_live <= 1'b1;
        slot_pos  <= spawn_pos;
      end else if (slot_live && i_FrameTick) begin
        // Leaving the top edge frees the slot and keeps the last position.
        if (pos_y(slot_pos) < SPEED_Y) begin
          slot_live <= 1'b0;
        end else begin
          slot_pos <= pack_pos(pos_x(slot_pos), pos_y(slot_pos) - SPEED_Y);
        end
      end
    end

    assign live[k] = slot_live;
    assign o_PlayerBulletPosition[k*POS_W +: POS_W] = slot_pos;
  end

  assign o_PlayerBulletState = live;
  assign o_FireAccept        = fire_accept;

endmodule
